// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared FSM state type and constants for the APB command master
package apb_pkg;

    localparam int DEFAULT_DATA_WIDTH     = 32;
    localparam int DEFAULT_ADDR_WIDTH     = 32;
    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

    localparam logic [2:0] PPROT_DEFAULT = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

endpackage

// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - single-outstanding command-to-APB4 requester (optional ACCESS timeout: APB_CMD_MASTER_TIMEOUT_EN)
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [2:0]              pprot,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic                    pready,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pslverr
);

    apb_state_e state;
    apb_state_e state_nxt;

    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] strb_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_err_q;
    logic                    timeout_hit;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;

    // The last permitted wait cycle: abandon ACCESS on the following edge
    assign timeout_hit = (state == ST_ACCESS) && !pready &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    // State register; reset abandons any transfer in flight
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control outputs
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                psel      = 1'b1;
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready || timeout_hit) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // APB payload comes from the latched command only while the bus is selected
    assign paddr     = psel ? addr_q  : '0;
    assign pwrite    = psel ? write_q : 1'b0;
    assign pwdata    = psel ? wdata_q : '0;
    assign pstrb     = psel ? strb_q  : '0;
    assign pprot     = PPROT_DEFAULT;
    assign rsp_rdata = rsp_valid ? rsp_rdata_q : '0;
    assign rsp_err   = rsp_valid ? rsp_err_q   : 1'b0;

    // Command latch, response capture and the optional ACCESS wait counter
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            strb_q      <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
        end else begin
            if (state == ST_IDLE && cmd_valid) begin
                addr_q  <= cmd_addr;
                write_q <= cmd_write;
                // Reads put zero data and strobes on the bus
                wdata_q <= cmd_write ? cmd_wdata : '0;
                strb_q  <= cmd_write ? cmd_strb  : '0;
            end
            if (state == ST_ACCESS) begin
                if (pready) begin
                    rsp_err_q   <= pslverr;
                    rsp_rdata_q <= (!write_q && !pslverr) ? prdata : '0;
                end else if (timeout_hit) begin
                    rsp_err_q   <= 1'b1;
                    rsp_rdata_q <= '0;
                end
            end
`ifdef APB_CMD_MASTER_TIMEOUT_EN
            if (state == ST_ACCESS && !pready) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
`endif
        end
    end

endmodule
